// File: rtl/gate_bist_ctrl.sv
// Exhaustive-vector BIST sequencer for a single AND/OR/XOR/NAND gate.
// Define GATE_BIST_FIRST_FAIL_EN to add fail_valid/fail_vec first-failure capture.
module gate_bist_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    output logic [N_IN-1:0] vec,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt
`ifdef GATE_BIST_FIRST_FAIL_EN
    ,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t            state;
    state_t            state_d;
    logic [1:0]        op_q;
    logic [1:0]        op_d;
    logic [N_IN-1:0]   vec_d;
    logic [3:0]        cnt;
    logic [3:0]        cnt_d;
    logic [N_IN:0]     err_d;
    logic              pass_d;
    logic              expect_y;
    logic              mismatch;

`ifdef GATE_BIST_FIRST_FAIL_EN
    logic              fv_d;
    logic [N_IN-1:0]   fvec_d;
`endif

    always_comb begin
        expect_y = 1'b0;
        unique case (op_q)
            2'b00: expect_y = &vec;
            2'b01: expect_y = |vec;
            2'b10: expect_y = ^vec;
            2'b11: expect_y = ~&vec;
            default: expect_y = 1'b0;
        endcase
    end

    assign mismatch = (dut_y != expect_y);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_d = state;
        op_d    = op_q;
        vec_d   = vec;
        cnt_d   = cnt;
        err_d   = err_cnt;
        pass_d  = pass;
`ifdef GATE_BIST_FIRST_FAIL_EN
        fv_d    = fail_valid;
        fvec_d  = fail_vec;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    vec_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = APPLY;
`ifdef GATE_BIST_FIRST_FAIL_EN
                    fv_d    = 1'b0;
                    fvec_d  = '0;
`endif
                end
            end
            APPLY: begin
                if (cnt == LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            CHECK: begin
                err_d = err_cnt + (N_IN + 1)'(mismatch);
`ifdef GATE_BIST_FIRST_FAIL_EN
                if (mismatch && !fail_valid) begin
                    fv_d   = 1'b1;
                    fvec_d = vec;
                end
`endif
                // All-ones is the last vector; vec is left there, not wrapped.
                if (&vec) begin
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    vec_d   = vec + 1'b1;
                    cnt_d   = '0;
                    state_d = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= 2'b00;
            vec     <= '0;
            cnt     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            state   <= state_d;
            op_q    <= op_d;
            vec     <= vec_d;
            cnt     <= cnt_d;
            err_cnt <= err_d;
            pass    <= pass_d;
        end
    end

`ifdef GATE_BIST_FIRST_FAIL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            fail_valid <= fv_d;
            fail_vec   <= fvec_d;
        end
    end
`endif

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for a single combinational logic gate (AND/OR/XOR/NAND family). The block steps the gate's inputs through every input combination and waits a programmable settle time per vector. It samples the gate output, compares it against the expected function, counts mismatches and reports pass/fail. It sits beside the gate primitives as the on-chip replacement for the hand-driven directed gate benches.

## Interface
Parameters:
- `N_IN`, default 2: number of gate inputs; legal range 2–8.
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range 1–15.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a test run; sampled only in IDLE.
- `op`, input, 2: expected function, latched when `start` is accepted.
  - 00: AND
  - 01: OR
  - 10: XOR
  - 11: NAND
  - All four are reductions over `N_IN` bits.
- `vec`, output, `N_IN`: stimulus driven onto the gate inputs.
- `dut_y`, input, 1: gate output under test.
- `busy`, output, 1: high from the cycle after start acceptance until DONE is left.
- `done`, output, 1: one-cycle pulse at run completion.
- `pass`, output, 1: run result; 1 = zero mismatches.
- `err_cnt`, output, `N_IN+1`: mismatch count.

## Operation
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE, `start`=1: latch `op`, `vec`←0, `err_cnt`←0, `pass`←0, settle counter←0, then go to APPLY.
- APPLY: hold `vec`; increment the settle counter. When the counter reaches `SETTLE`−1, go to CHECK.
- CHECK, one cycle: at the exiting edge, compare `dut_y` with expected(`op`, `vec`). On mismatch, `err_cnt`←`err_cnt`+1.
  - If `vec` = all ones, go to DONE.
  - Otherwise `vec`←`vec`+1, clear the settle counter and go to APPLY.
- DONE, one cycle: `done`=1, `busy`=1. `pass` and `err_cnt` are registered at the edge entering DONE, where `pass` = (final `err_cnt`==0). Next state is IDLE.
- `pass`, `err_cnt` and last `vec` hold in IDLE until the next accepted `start` or reset.
- `start` in any non-IDLE state is ignored; it is not queued.
- `err_cnt` cannot saturate: its maximum is 2^`N_IN`, which fits in `N_IN`+1 bits.
- `vec` never wraps within a run; all-ones terminates the run.

## Timing
- Reset, asynchronous and effective immediately, in any state including mid-run:
  - state = IDLE
  - `vec`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0
- Define edge 0 as the edge that samples `start`=1 in IDLE. The DONE state is entered at edge 2^`N_IN`·(`SETTLE`+1).
  - `done` is high for exactly that cycle.
  - `busy` falls at the following edge.
- Each vector is stable for `SETTLE`+1 cycles. `dut_y` is sampled at the last edge of that window.
- `start` held high through DONE: not accepted in DONE. It is accepted on the first IDLE cycle, so back-to-back runs are separated by one IDLE cycle.

## Configuration
- `GATE_BIST_FIRST_FAIL_EN` defined: adds two outputs.
  - `fail_valid`, 1 bit.
  - `fail_vec`, `N_IN` bits.
  - Both reset to 0 and clear on `start` acceptance.
  - On the first mismatch of a run, `fail_vec`←`vec` and `fail_valid`←1.
  - Later mismatches do not overwrite them. Both hold until the next `start` or reset.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
1. **Ideal OR:** `N_IN`=2, `SETTLE`=1, `op`=01, `dut_y`=|`vec` → `vec` sequence 00,01,10,11; `done` at edge 8; `pass`=1, `err_cnt`=0, `fail_valid`=0.
2. **Stuck-at-0:** same setup, `dut_y` tied 0 → `err_cnt`=3, `pass`=0, `fail_vec`=01, `fail_valid`=1.
3. **Wrong function:** `op`=10 (XOR) with a real OR gate → `err_cnt`=1, `fail_vec`=11, `pass`=0.
4. **Wider gate, longer settle:** `N_IN`=3, `SETTLE`=2, `op`=00, ideal AND → `done` at edge 24, `err_cnt`=0, final `vec`=111.
5. **Start ignored, then reset mid-run:** pulse `start` while `vec`=01 → no effect, and `done` still arrives at edge 8. In a second run, assert `rst` while `vec`=10 → all outputs 0 and IDLE immediately. A fresh `start` after that completes normally with the correct result.
6. **Held start:** hold `start` high continuously → runs repeat with exactly one IDLE cycle between `done` pulses. `err_cnt` clears at each acceptance.
